// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - multi-lane EX pipeline register with 2-entry skid, flush, lane kill and exception hold
module pipe_skid_stage #(
    parameter int LANES  = 2,
    parameter int DATA_W = 128,
    parameter int SKID   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_lane_valid,
    input  logic [LANES-1:0]         in_excp,
    input  logic [LANES*DATA_W-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         out_lane_valid,
    output logic [LANES-1:0]         out_excp,
    output logic [LANES*DATA_W-1:0]  out_data,
    output logic [1:0]               occupancy,
    output logic                     excp_hold
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [LANES-1:0]          main_lv_q, main_lv_d, main_ex_q, main_ex_d;
    logic [LANES-1:0]          skid_lv_q, skid_lv_d, skid_ex_q, skid_ex_d;
    logic [LANES*DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic                      excp_hold_q, excp_hold_d;
    logic                      in_ready_q, in_ready_d;

    logic [LANES-1:0]          kill_lv, kill_ex;
    logic                      excp_seen;
    logic                      push, pop, store;

    // Everything younger than the oldest valid excepting lane is squashed.
    always_comb begin
        excp_seen = 1'b0;
        kill_lv   = '0;
        kill_ex   = '0;
        for (int i = 0; i < LANES; i++) begin
            kill_lv[i] = in_lane_valid[i] & ~excp_seen;
            kill_ex[i] = in_excp[i] & ~excp_seen;
            excp_seen  = excp_seen | (in_lane_valid[i] & in_excp[i]);
        end
    end

    assign out_valid      = (state_q != ST_EMPTY);
    assign out_lane_valid = main_lv_q;
    assign out_excp       = main_ex_q;
    assign out_data       = main_data_q;
    assign excp_hold      = excp_hold_q;
    assign occupancy      = (state_q == ST_TWO) ? 2'd2 :
                            (state_q == ST_ONE) ? 2'd1 : 2'd0;

    assign in_ready = (SKID != 0) ? (in_ready_q & ~reset)
                                  : (~reset & ~excp_hold_q & (~out_valid | out_ready));

    assign push  = in_valid & in_ready;
    assign pop   = out_valid & out_ready;
    assign store = push & (|kill_lv);

    always_comb begin
        state_d     = state_q;
        main_lv_d   = main_lv_q;
        main_ex_d   = main_ex_q;
        main_data_d = main_data_q;
        skid_lv_d   = skid_lv_q;
        skid_ex_d   = skid_ex_q;
        skid_data_d = skid_data_q;
        excp_hold_d = excp_hold_q | (store & (|kill_ex));
        if (flush) begin
            state_d     = ST_EMPTY;
            main_lv_d   = '0;
            main_ex_d   = '0;
            main_data_d = '0;
            skid_lv_d   = '0;
            skid_ex_d   = '0;
            skid_data_d = '0;
            excp_hold_d = 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (store) begin
                        state_d     = ST_ONE;
                        main_lv_d   = kill_lv;
                        main_ex_d   = kill_ex;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (store && pop) begin
                        main_lv_d   = kill_lv;
                        main_ex_d   = kill_ex;
                        main_data_d = in_data;
                    end else if (store) begin
                        state_d     = ST_TWO;
                        skid_lv_d   = kill_lv;
                        skid_ex_d   = kill_ex;
                        skid_data_d = in_data;
                    end else if (pop) begin
                        state_d     = ST_EMPTY;
                        main_lv_d   = '0;
                        main_ex_d   = '0;
                        main_data_d = '0;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d     = ST_ONE;
                        main_lv_d   = skid_lv_q;
                        main_ex_d   = skid_ex_q;
                        main_data_d = skid_data_q;
                        skid_lv_d   = '0;
                        skid_ex_d   = '0;
                        skid_data_d = '0;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        // Ready is decided a cycle early so it never depends on out_ready.
        in_ready_d = ~excp_hold_d & (state_d != ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_lv_q   <= '0;
            main_ex_q   <= '0;
            main_data_q <= '0;
            skid_lv_q   <= '0;
            skid_ex_q   <= '0;
            skid_data_q <= '0;
            excp_hold_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_lv_q   <= main_lv_d;
            main_ex_q   <= main_ex_d;
            main_data_q <= main_data_d;
            skid_lv_q   <= skid_lv_d;
            skid_ex_q   <= skid_ex_d;
            skid_data_q <= skid_data_d;
            excp_hold_q <= excp_hold_d;
            in_ready_q  <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - randomized and directed bench for pipe_skid_stage against a packet-queue model
module tb_pipe_skid_stage;

    localparam int L  = 2;
    localparam int DW = 32;

    typedef struct packed {
        logic [L-1:0]    lv;
        logic [L-1:0]    ex;
        logic [L*DW-1:0] d;
    } pkt_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic [L-1:0]    in_lv = '0;
    logic [L-1:0]    in_ex = '0;
    logic [L*DW-1:0] in_data = '0;
    logic            out_ready = 1'b0;

    logic            r1, ov1, eh1, r0, ov0, eh0;
    logic [L-1:0]    olv1, oex1, olv0, oex0;
    logic [L*DW-1:0] od1, od0;
    logic [1:0]      occ1, occ0;

    logic            o_rdy, o_valid, o_hold;
    logic [L-1:0]    o_lv, o_ex;
    logic [L*DW-1:0] o_data;
    logic [1:0]      o_occ;

    bit   m_skid = 1'b1;
    bit   in_reset = 1'b1;
    bit   hold = 1'b0;
    bit   rdy_reg = 1'b0;
    pkt_t q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.LANES(L), .DATA_W(DW), .SKID(1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r1),
        .in_lane_valid(in_lv), .in_excp(in_ex), .in_data(in_data), .out_valid(ov1),
        .out_ready(out_ready), .out_lane_valid(olv1), .out_excp(oex1), .out_data(od1),
        .occupancy(occ1), .excp_hold(eh1));

    pipe_skid_stage #(.LANES(L), .DATA_W(DW), .SKID(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r0),
        .in_lane_valid(in_lv), .in_excp(in_ex), .in_data(in_data), .out_valid(ov0),
        .out_ready(out_ready), .out_lane_valid(olv0), .out_excp(oex0), .out_data(od0),
        .occupancy(occ0), .excp_hold(eh0));

    assign o_rdy   = m_skid ? r1   : r0;
    assign o_valid = m_skid ? ov1  : ov0;
    assign o_hold  = m_skid ? eh1  : eh0;
    assign o_lv    = m_skid ? olv1 : olv0;
    assign o_ex    = m_skid ? oex1 : oex0;
    assign o_data  = m_skid ? od1  : od0;
    assign o_occ   = m_skid ? occ1 : occ0;

    function automatic bit exp_rdy();
        if (in_reset) return 1'b0;
        if (m_skid) return rdy_reg;
        return !hold && (q.size() == 0 || out_ready);
    endfunction

    function automatic pkt_t apply_kill(logic [L-1:0] lv, logic [L-1:0] ex, logic [L*DW-1:0] d);
        pkt_t p;
        int   e = L;
        for (int i = L - 1; i >= 0; i--) if (lv[i] && ex[i]) e = i;
        p.lv = lv;
        p.ex = ex;
        p.d  = d;
        for (int i = 0; i < L; i++) if (i > e) begin p.lv[i] = 1'b0; p.ex[i] = 1'b0; end
        return p;
    endfunction

    task automatic offer(bit v, logic [L-1:0] lv, logic [L-1:0] ex, logic [L*DW-1:0] d, bit ordy, bit fl);
        in_valid = v; in_lv = lv; in_ex = ex; in_data = d; out_ready = ordy; flush = fl;
    endtask

    // Advance the model by one clock using the inputs currently driven, then wait for the next negedge.
    task automatic tick();
        bit   push, pop;
        pkt_t p;
        #1;
        push = in_valid && exp_rdy();
        pop  = (q.size() > 0) && out_ready;
        if (flush) begin
            q.delete();
            hold = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                p = apply_kill(in_lv, in_ex, in_data);
                if (|p.lv) begin
                    q.push_back(p);
                    if (|p.ex) hold = 1'b1;
                end
            end
        end
        rdy_reg = !hold && (q.size() < 2);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; in_reset = 1'b1;
        offer(0, '0, '0, '0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        q.delete(); hold = 1'b0; rdy_reg = 1'b1;
    endtask

    task automatic test_reset();
        m_skid = 1'b1;
        do_reset();
        checks += 6;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
        if (o_occ !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", o_occ); end
        if (o_data !== '0) begin failures++; $display("FAIL reset_data got=%0h exp=0", o_data); end
        if (o_lv !== '0 || o_ex !== '0) begin failures++; $display("FAIL reset_lanes got=%0b/%0b exp=0/0", o_lv, o_ex); end
        if (o_hold !== 1'b0) begin failures++; $display("FAIL reset_hold got=%0b exp=0", o_hold); end
        if (o_rdy !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", o_rdy); end
        reset = 1'b0; in_reset = 1'b0;
        #1;
        checks++;
        if (o_rdy !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%0b exp=1", o_rdy); end
    endtask

    task automatic test_stream();
        logic [L*DW-1:0] pk[3];
        for (int k = 0; k < 3; k++) pk[k] = {$urandom, $urandom};
        for (int k = 0; k < 4; k++) begin
            if (k < 3) offer(1, 2'b11, 2'b00, pk[k], 1, 0);
            else       offer(0, 2'b00, 2'b00, '0, 1, 0);
            tick();
            if (k < 3) begin
                checks += 3;
                if (o_data !== pk[k]) begin failures++; $display("FAIL stream_data%0d got=%0h exp=%0h", k, o_data, pk[k]); end
                if (o_occ !== 2'd1) begin failures++; $display("FAIL stream_occ%0d got=%0d exp=1", k, o_occ); end
                if (o_rdy !== 1'b1) begin failures++; $display("FAIL stream_ready%0d got=%0b exp=1", k, o_rdy); end
            end
        end
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%0b exp=0", o_valid); end
    endtask

    task automatic test_backpressure();
        logic [L*DW-1:0] a, b;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        offer(1, 2'b11, 2'b00, a, 0, 0); tick();
        checks += 2;
        if (o_occ !== 2'd1) begin failures++; $display("FAIL bp_occ_a got=%0d exp=1", o_occ); end
        if (o_rdy !== 1'b1) begin failures++; $display("FAIL bp_ready_a got=%0b exp=1", o_rdy); end
        offer(1, 2'b01, 2'b00, b, 0, 0); tick();
        checks += 3;
        if (o_occ !== 2'd2) begin failures++; $display("FAIL bp_occ_b got=%0d exp=2", o_occ); end
        if (o_rdy !== 1'b0) begin failures++; $display("FAIL bp_ready_b got=%0b exp=0", o_rdy); end
        if (o_data !== a) begin failures++; $display("FAIL bp_head_a got=%0h exp=%0h", o_data, a); end
        offer(0, 2'b00, 2'b00, '0, 1, 0); tick();
        checks += 3;
        if (o_data !== b) begin failures++; $display("FAIL bp_head_b got=%0h exp=%0h", o_data, b); end
        if (o_lv !== 2'b01) begin failures++; $display("FAIL bp_lv_b got=%0b exp=01", o_lv); end
        if (o_occ !== 2'd1) begin failures++; $display("FAIL bp_occ_drain got=%0d exp=1", o_occ); end
        tick();
        checks++;
        if (o_occ !== 2'd0) begin failures++; $display("FAIL bp_occ_empty got=%0d exp=0", o_occ); end
    endtask

    task automatic test_kill();
        logic [L*DW-1:0] a;
        a = {$urandom, $urandom};
        offer(1, 2'b11, 2'b01, a, 0, 0); tick();
        checks += 5;
        if (o_lv !== 2'b01) begin failures++; $display("FAIL kill_lv got=%0b exp=01", o_lv); end
        if (o_ex !== 2'b01) begin failures++; $display("FAIL kill_ex got=%0b exp=01", o_ex); end
        if (o_data !== a) begin failures++; $display("FAIL kill_data got=%0h exp=%0h", o_data, a); end
        if (o_hold !== 1'b1) begin failures++; $display("FAIL kill_hold got=%0b exp=1", o_hold); end
        if (o_rdy !== 1'b0) begin failures++; $display("FAIL kill_ready got=%0b exp=0", o_rdy); end
        offer(1, 2'b11, 2'b00, {$urandom, $urandom}, 1, 0); tick(); tick();
        checks += 3;
        if (o_occ !== 2'd0) begin failures++; $display("FAIL kill_drain_occ got=%0d exp=0", o_occ); end
        if (o_hold !== 1'b1) begin failures++; $display("FAIL kill_hold_kept got=%0b exp=1", o_hold); end
        if (o_rdy !== 1'b0) begin failures++; $display("FAIL kill_ready_kept got=%0b exp=0", o_rdy); end
        offer(0, 2'b00, 2'b00, '0, 1, 1); tick();
        flush = 1'b0;
        checks += 2;
        if (o_hold !== 1'b0) begin failures++; $display("FAIL kill_flush_hold got=%0b exp=0", o_hold); end
        if (o_rdy !== 1'b1) begin failures++; $display("FAIL kill_flush_ready got=%0b exp=1", o_rdy); end
    endtask

    task automatic test_drop();
        offer(1, 2'b00, 2'b11, {$urandom, $urandom}, 0, 0);
        #1;
        checks++;
        if (o_rdy !== 1'b1) begin failures++; $display("FAIL drop_handshake got=%0b exp=1", o_rdy); end
        tick();
        offer(0, 2'b00, 2'b00, '0, 0, 0);
        checks += 3;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL drop_valid got=%0b exp=0", o_valid); end
        if (o_occ !== 2'd0) begin failures++; $display("FAIL drop_occ got=%0d exp=0", o_occ); end
        if (o_hold !== 1'b0) begin failures++; $display("FAIL drop_hold got=%0b exp=0", o_hold); end
    endtask

    task automatic test_flush_two();
        offer(1, 2'b11, 2'b00, {$urandom, $urandom}, 0, 0); tick();
        offer(1, 2'b10, 2'b00, {$urandom, $urandom}, 0, 0); tick();
        checks++;
        if (o_occ !== 2'd2) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=2", o_occ); end
        offer(1, 2'b11, 2'b00, {$urandom, $urandom}, 1, 1); tick();
        checks += 5;
        if (o_occ !== 2'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", o_occ); end
        if (o_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", o_valid); end
        if (o_data !== '0) begin failures++; $display("FAIL flush_data got=%0h exp=0", o_data); end
        if (o_hold !== 1'b0) begin failures++; $display("FAIL flush_hold got=%0b exp=0", o_hold); end
        if (o_rdy !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0b exp=1", o_rdy); end
        offer(0, 2'b00, 2'b00, '0, 1, 0); tick();
        checks++;
        if (o_occ !== 2'd0) begin failures++; $display("FAIL flush_not_stored got=%0d exp=0", o_occ); end
    endtask

    task automatic test_skid0();
        m_skid = 1'b0;
        do_reset();
        reset = 1'b0; in_reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            checks += 2;
            if (o_occ > 2'd1) begin failures++; $display("FAIL skid0_occ_max got=%0d exp<=1", o_occ); end
            if (o_occ !== 2'(q.size())) begin failures++; $display("FAIL skid0_occ got=%0d exp=%0d", o_occ, q.size()); end
            offer(1, 2'($urandom_range(1, 3)), 2'b00, {$urandom, $urandom}, (k % 3) != 1, 0);
            #1;
            checks++;
            if (o_rdy !== exp_rdy()) begin failures++; $display("FAIL skid0_ready c%0d got=%0b exp=%0b", k, o_rdy, exp_rdy()); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int m = 1; m >= 0; m--) begin
            m_skid = bit'(m);
            do_reset();
            reset = 1'b0; in_reset = 1'b0;
            for (int k = 0; k < 300; k++) begin
                checks += 3;
                if (o_valid !== (q.size() > 0)) begin failures++; $display("FAIL rnd_valid m%0d c%0d got=%0b exp=%0b", m, k, o_valid, q.size() > 0); end
                if (o_occ !== 2'(q.size())) begin failures++; $display("FAIL rnd_occ m%0d c%0d got=%0d exp=%0d", m, k, o_occ, q.size()); end
                if (o_hold !== hold) begin failures++; $display("FAIL rnd_hold m%0d c%0d got=%0b exp=%0b", m, k, o_hold, hold); end
                if (q.size() > 0) begin
                    checks++;
                    if ({o_lv, o_ex, o_data} !== {q[0].lv, q[0].ex, q[0].d})
                        begin failures++; $display("FAIL rnd_head m%0d c%0d got=%0b/%0b/%0h exp=%0b/%0b/%0h", m, k, o_lv, o_ex, o_data, q[0].lv, q[0].ex, q[0].d); end
                end
                offer($urandom_range(0, 3) != 0, 2'($urandom), ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00,
                      {$urandom, $urandom}, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
                #1;
                checks++;
                if (o_rdy !== exp_rdy()) begin failures++; $display("FAIL rnd_ready m%0d c%0d got=%0b exp=%0b", m, k, o_rdy, exp_rdy()); end
                tick();
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_kill();
        test_drop();
        test_flush_two();
        test_skid0();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
